// File: rtl/rnsrt_pkg.sv
`default_nettype none
// ============================================================================
// Module : rnsrt_pkg
// Brief  : Types shared by the ring-side issuer and the bus-side region caches.
// Rev    : 1.0  initial release
// ============================================================================
package rnsrt_pkg;

  typedef enum logic {
    RNSRT_INSERT     = 1'b0,
    RNSRT_INVALIDATE = 1'b1
  } rnsrt_op_t;

  typedef struct packed {
    logic [31:0] address;
    rnsrt_op_t   op;
  } rnsrt_req_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_SWEEP = 2'd2
  } rnsrt_issuer_state_t;

endpackage
`default_nettype wire

// File: rtl/rnsrt_interface.sv
`default_nettype none
// ============================================================================
// Module : rnsrt_interface
// Brief  : Insert/invalidate strobe bundle from the ring issuer to bus caches.
// Rev    : 1.0  initial release
// ============================================================================
interface rnsrt_interface;
  logic [31:0] address;
  logic        insert;
  logic        invalidate;

  modport ring (output address, output insert, output invalidate);
  modport bus  (input  address, input  insert, input  invalidate);
endinterface
`default_nettype wire

// File: rtl/rnsrt_fifo.sv
`default_nettype none
// ============================================================================
// Module : rnsrt_fifo
// Brief  : Synchronous FIFO with extra-wrap-bit pointers and occupancy output.
// Rev    : 1.0  initial release
// ============================================================================
module rnsrt_fifo
  import rnsrt_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = rnsrt_req_t
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int c_AW = $clog2(DEPTH);

  logic [c_AW:0] r_wr_ptr;
  logic [c_AW:0] r_rd_ptr;
  T              r_mem [DEPTH];
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
  end

  assign pop_data = r_mem[r_rd_ptr[c_AW-1:0]];
  assign empty    = (r_wr_ptr == r_rd_ptr);
  assign full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                    (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign level    = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire

// File: rtl/rnsrt_ring_issuer.sv
`default_nettype none
// ============================================================================
// Module : rnsrt_ring_issuer
// Brief  : Buffers ring insert/invalidate requests and emits gap-spaced strobes;
//          flush drains the queue then invalidates every cache index.
// Rev    : 1.0  initial release
// ============================================================================
module rnsrt_ring_issuer
  import rnsrt_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int GAP_CYCLES   = 1,
  parameter int INDEX_WIDTH  = 2,
  parameter int OFFSET_WIDTH = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_address,
  input  rnsrt_op_t       req_op,
  input  logic            flush,
  output logic            flush_busy,
  rnsrt_interface.ring    ring
);

  localparam int                 c_GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(GAP_CYCLES);
  localparam int                 c_LVL_W    = $clog2(DEPTH) + 1;
  localparam logic [c_LVL_W-1:0] c_DEPTH    = c_LVL_W'(DEPTH);

  rnsrt_issuer_state_t r_state;
  rnsrt_issuer_state_t w_state_next;

  logic [c_GAP_W-1:0]   r_gap;
  logic [INDEX_WIDTH:0] r_idx;
  logic                 r_stage_valid;
  rnsrt_req_t           r_stage;
  logic [31:0]          r_address;
  logic                 r_insert;
  logic                 r_invalidate;
  logic                 r_req_ready;
  logic                 r_flush_busy;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_sweep_issue;
  logic                 w_gap_zero;
  logic                 w_full;
  logic                 w_empty;
  logic [c_LVL_W-1:0]   w_level;
  logic [c_LVL_W-1:0]   w_level_next;
  rnsrt_req_t           w_push_data;
  rnsrt_req_t           w_fifo_head;
  logic [31:0]          w_sweep_addr;

  assign w_push       = req_valid && r_req_ready;
  assign w_gap_zero   = (r_gap == '0);
  assign w_push_data  = '{address: req_address, op: req_op};
  assign w_sweep_addr = 32'(r_idx[INDEX_WIDTH-1:0]) << OFFSET_WIDTH;
  assign w_level_next = w_level + {{(c_LVL_W-1){1'b0}}, w_push}
                                - {{(c_LVL_W-1){1'b0}}, w_pop};

  rnsrt_fifo #(
    .DEPTH (DEPTH),
    .T     (rnsrt_req_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .pop_data  (w_fifo_head),
    .full      (w_full),
    .empty     (w_empty),
    .level     (w_level)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_pop         = 1'b0;
    w_sweep_issue = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pop = !w_empty && w_gap_zero;
        if (flush) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_pop = !w_empty && w_gap_zero;
        if (w_empty && w_gap_zero) w_state_next = S_SWEEP;
      end
      S_SWEEP: begin
        // The extra index bit marks "last index already issued".
        if (r_idx[INDEX_WIDTH]) w_state_next  = S_IDLE;
        else                    w_sweep_issue = w_gap_zero;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_gap         <= '0;
      r_idx         <= '0;
      r_stage_valid <= 1'b0;
      r_stage       <= '0;
      r_address     <= '0;
      r_insert      <= 1'b0;
      r_invalidate  <= 1'b0;
      r_req_ready   <= 1'b0;
      r_flush_busy  <= 1'b0;
    end else begin
      // Ready is registered from next-cycle occupancy and state.
      r_req_ready  <= (w_level_next != c_DEPTH) && (w_state_next == S_IDLE);
      r_flush_busy <= (w_state_next != S_IDLE);

      if (w_pop || w_sweep_issue) r_gap <= c_GAP_LOAD;
      else if (!w_gap_zero)       r_gap <= r_gap - c_GAP_W'(1);

      if (r_state == S_DRAIN && w_state_next == S_SWEEP) r_idx <= '0;
      else if (w_sweep_issue) r_idx <= r_idx + (INDEX_WIDTH+1)'(1);

      r_stage_valid <= w_pop || w_sweep_issue;
      if (w_pop)              r_stage <= w_fifo_head;
      else if (w_sweep_issue) r_stage <= '{address: w_sweep_addr, op: RNSRT_INVALIDATE};

      r_insert     <= r_stage_valid && (r_stage.op == RNSRT_INSERT);
      r_invalidate <= r_stage_valid && (r_stage.op == RNSRT_INVALIDATE);
      if (r_stage_valid) r_address <= r_stage.address;
    end
  end

  assign req_ready       = r_req_ready;
  assign flush_busy      = r_flush_busy;
  assign ring.address    = r_address;
  assign ring.insert     = r_insert;
  assign ring.invalidate = r_invalidate;

endmodule
`default_nettype wire

// File: tb/tb_rnsrt_ring_issuer.sv
`default_nettype none
// ============================================================================
// Module : tb_rnsrt_ring_issuer
// Brief  : Self-checking bench: vector table, directed corner sequences and
//          randomized traffic against a queue-based strobe-stream model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rnsrt_ring_issuer;
  import rnsrt_pkg::*;

  localparam int DEPTH  = 4;
  localparam int GAP    = 1;
  localparam int IW     = 2;
  localparam int OFF    = 6;
  localparam int NSWEEP = 1 << IW;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_address;
  rnsrt_op_t   req_op;
  logic        flush;
  logic        flush_busy;

  always #5 clk = ~clk;

  rnsrt_interface u_ring ();

  rnsrt_ring_issuer #(
    .DEPTH(DEPTH), .GAP_CYCLES(GAP), .INDEX_WIDTH(IW), .OFFSET_WIDTH(OFF)
  ) dut (
    .clock(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_address(req_address), .req_op(req_op), .flush(flush),
    .flush_busy(flush_busy), .ring(u_ring)
  );

  int errors = 0;
  int checks = 0;
  int stall_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected strobe stream: accepted requests in order, plus one full sweep per accepted flush.
  typedef struct { logic [31:0] addr; logic inv; logic last; } exp_t;
  typedef struct { int cyc; logic [31:0] addr; logic ins; logic inv; logic busy; } log_t;

  exp_t        exp_q[$];
  log_t        slog[$];
  logic        model_busy = 1'b0;
  logic [31:0] model_addr = 32'h0;
  int          cyc = 0;
  int          last_strobe = -1000;
  logic        rst_q = 1'b1;

  always @(posedge clk) rst_q <= reset;

  always @(negedge clk) begin
    cyc++;
    if (rst_q) begin
      check("reset_insert", {31'b0, u_ring.insert}, 0);
      check("reset_invalidate", {31'b0, u_ring.invalidate}, 0);
      check("reset_address", u_ring.address, 0);
      check("reset_ready", {31'b0, req_ready}, 0);
      check("reset_busy", {31'b0, flush_busy}, 0);
      exp_q.delete();
      model_busy  = 1'b0;
      model_addr  = 32'h0;
      last_strobe = -1000;
    end else begin
      check("strobe_exclusive", {31'b0, u_ring.insert & u_ring.invalidate}, 0);
      if (u_ring.insert || u_ring.invalidate) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got addr 0x%08h with nothing pending", u_ring.address);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("strobe_address", u_ring.address, e.addr);
          check("strobe_op", {31'b0, u_ring.invalidate}, {31'b0, e.inv});
          model_addr = e.addr;
          if (e.last) model_busy = 1'b0;
        end
        check("strobe_gap", {31'b0, (cyc - last_strobe) >= GAP + 1}, 1);
        last_strobe = cyc;
        slog.push_back('{cyc, u_ring.address, u_ring.insert, u_ring.invalidate, flush_busy});
      end else begin
        check("address_hold", u_ring.address, model_addr);
      end
      check("flush_busy", {31'b0, flush_busy}, {31'b0, model_busy});
      if (model_busy) check("ready_low_busy", {31'b0, req_ready}, 0);
    end
    if (!reset) begin
      if (req_valid && req_ready)
        exp_q.push_back('{req_address, req_op == RNSRT_INVALIDATE, 1'b0});
      if (flush && !model_busy) begin
        model_busy = 1'b1;
        for (int i = 0; i < NSWEEP; i++)
          exp_q.push_back('{32'(i) << OFF, 1'b1, i == NSWEEP - 1});
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input rnsrt_op_t op, input logic [31:0] a);
    logic done;
    done        = 1'b0;
    req_valid   = 1'b1;
    req_op      = op;
    req_address = a;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (req_ready) done = 1'b1;
      else stall_cycles++;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept for 0x%08h within 200 cycles", a);
    end
  endtask

  task automatic wait_quiet();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      if (exp_q.size() == 0 && !model_busy) done = 1'b1;
      else cycles(1);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL quiet_timeout: got %0d strobes still pending, required 0", exp_q.size());
    end
    cycles(3);
  endtask

  task automatic wait_strobe(output int n, output logic [31:0] a, output logic ins, output logic inv);
    n = 0; a = '0; ins = 1'b0; inv = 1'b0;
    for (int k = 1; k <= 50 && n == 0; k++) begin
      @(negedge clk);
      if (u_ring.insert || u_ring.invalidate) begin
        n = k; a = u_ring.address; ins = u_ring.insert; inv = u_ring.invalidate;
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    rnsrt_op_t   op;
    logic [31:0] addr;
    logic        exp_ins;
    logic        exp_inv;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          n;
    int          sweep_cnt;
    logic [31:0] a;
    logic        ins;
    logic        inv;
    logic        found;

    vecs[0] = '{RNSRT_INSERT,     32'h0000_1000, 1'b1, 1'b0, 32'h0000_1000};
    vecs[1] = '{RNSRT_INVALIDATE, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{RNSRT_INSERT,     32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF};
    vecs[3] = '{RNSRT_INVALIDATE, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000};
    vecs[4] = '{RNSRT_INSERT,     32'h8000_0000, 1'b1, 1'b0, 32'h8000_0000};
    vecs[5] = '{RNSRT_INVALIDATE, 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678};

    reset = 1'b1; req_valid = 1'b0; req_address = '0; req_op = RNSRT_INSERT; flush = 1'b0;
    cycles(3);
    reset = 1'b0;

    // Single requests: two-edge latency, one-cycle strobe, correct op and address.
    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].addr);
      req_valid = 1'b0;
      wait_strobe(n, a, ins, inv);
      check("vec_latency", 32'(n), 3);
      check("vec_address", a, vecs[i].exp_addr);
      check("vec_insert", {31'b0, ins}, {31'b0, vecs[i].exp_ins});
      check("vec_invalidate", {31'b0, inv}, {31'b0, vecs[i].exp_inv});
      cycles(3);
    end

    // Back-to-back requests are spaced by the gap and keep their order.
    slog.delete();
    send(RNSRT_INSERT, 32'h0000_A000);
    send(RNSRT_INVALIDATE, 32'h0000_B000);
    send(RNSRT_INSERT, 32'h0000_C000);
    req_valid = 1'b0;
    wait_quiet();
    check("b2b_count", 32'(slog.size()), 3);
    if (slog.size() == 3) begin
      check("b2b_spacing_1", 32'(slog[1].cyc - slog[0].cyc), 2);
      check("b2b_spacing_2", 32'(slog[2].cyc - slog[1].cyc), 2);
      check("b2b_addr_a", slog[0].addr, 32'h0000_A000);
      check("b2b_addr_b", slog[1].addr, 32'h0000_B000);
      check("b2b_addr_c", slog[2].addr, 32'h0000_C000);
      check("b2b_op_b", {31'b0, slog[1].inv}, 1);
    end

    // Overfill: backpressure appears and the held request is issued last.
    slog.delete();
    stall_cycles = 0;
    for (int k = 0; k < 8; k++)
      send((k % 2 == 0) ? RNSRT_INSERT : RNSRT_INVALIDATE, 32'h0001_0000 + 32'(k) * 32'h100);
    req_valid = 1'b0;
    check("full_backpressure", {31'b0, stall_cycles > 0}, 1);
    wait_quiet();
    check("full_count", 32'(slog.size()), 8);
    if (slog.size() == 8) check("full_last_addr", slog[7].addr, 32'h0001_0700);

    // Flush behind two queued entries: drain first, then the index sweep.
    slog.delete();
    send(RNSRT_INSERT, 32'h0002_0000);
    send(RNSRT_INVALIDATE, 32'h0003_0000);
    req_valid = 1'b0;
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    wait_quiet();
    check("flush_count", 32'(slog.size()), 6);
    if (slog.size() == 6) begin
      check("flush_first", slog[0].addr, 32'h0002_0000);
      check("flush_second", slog[1].addr, 32'h0003_0000);
      for (int i = 0; i < NSWEEP; i++) begin
        check("flush_sweep_addr", slog[2+i].addr, 32'(i) << OFF);
        check("flush_sweep_inv", {31'b0, slog[2+i].inv}, 1);
      end
      check("flush_busy_before_last", {31'b0, slog[4].busy}, 1);
      check("flush_busy_at_last", {31'b0, slog[5].busy}, 0);
    end

    // Reset in the middle of a sweep discards the rest.
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (u_ring.invalidate && u_ring.address == 32'h0000_0040) found = 1'b1;
    end
    check("sweep_idx1_seen", {31'b0, found}, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    slog.delete();
    cycles(1);
    @(negedge clk);
    check("post_reset_ready", {31'b0, req_ready}, 1);
    check("post_reset_busy", {31'b0, flush_busy}, 0);
    cycles(10);
    check("post_reset_silent", 32'(slog.size()), 0);

    // A second flush while draining is ignored: exactly one sweep.
    slog.delete();
    send(RNSRT_INSERT, 32'h0004_0000);
    send(RNSRT_INSERT, 32'h0005_0000);
    req_valid = 1'b0;
    flush = 1'b1;
    cycles(3);
    flush = 1'b0;
    wait_quiet();
    sweep_cnt = 0;
    foreach (slog[i])
      if (slog[i].inv && (slog[i].addr & ~32'h0000_00C0) == 32'h0) sweep_cnt++;
    check("reflush_total", 32'(slog.size()), 6);
    check("reflush_sweeps", 32'(sweep_cnt), 4);

    // Randomized traffic with occasional flushes.
    for (int it = 0; it < 300; it++) begin
      flush = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 2) != 0) send(rnsrt_op_t'($urandom_range(0, 1)), $urandom());
      else begin
        req_valid = 1'b0;
        cycles(1);
      end
      flush = 1'b0;
    end
    req_valid = 1'b0;
    flush = 1'b0;
    wait_quiet();
    check("random_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish before 2 ms");
    $fatal(1);
  end

endmodule
`default_nettype wire
